// File: rtl/change_dispenser_if.sv
// Purchase request, coin hopper handshake and status bundle for change_dispenser.
// The slave modport is the dispenser; the master modport is the purchase FSM / hopper side.
interface change_dispenser_if #(
  parameter int MONEY_W  = 8,
  parameter int PRICE_W  = 4,
  parameter int AMOUNT_W = 2
) ();
  logic                start;
  logic                flat_mode;
  logic [AMOUNT_W-1:0] amount;
  logic [PRICE_W-1:0]  unit_price;
  logic [PRICE_W-1:0]  ticket_price;
  logic [MONEY_W-1:0]  real_pay;
  logic                busy;
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                coin_ready;
  logic [MONEY_W-1:0]  change;
  logic [MONEY_W-1:0]  remaining;
  logic                underpay;
  logic                done;
  logic [31:0]         dispdata;

  modport master (
    output start, flat_mode, amount, unit_price, ticket_price, real_pay, coin_ready,
    input  busy, coin_valid, coin_sel, change, remaining, underpay, done, dispdata
  );

  modport slave (
    input  start, flat_mode, amount, unit_price, ticket_price, real_pay, coin_ready,
    output busy, coin_valid, coin_sel, change, remaining, underpay, done, dispdata
  );
endinterface

// File: rtl/change_dispenser.sv
// Computes change owed and pays it out greedily one coin per valid/ready handshake.
// start->first coin 2 cycles; coin_sel/remaining hold while coin_ready is low.
module change_dispenser #(
  parameter int MONEY_W   = 8,
  parameter int PRICE_W   = 4,
  parameter int AMOUNT_W  = 2,
  parameter int DENOM_HI  = 10,
  parameter int DENOM_MID = 5,
  parameter int DENOM_LO  = 1
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DISPENSE, DONE} state_t;

  localparam logic [MONEY_W-1:0] HI  = MONEY_W'(DENOM_HI);
  localparam logic [MONEY_W-1:0] MID = MONEY_W'(DENOM_MID);
  localparam logic [MONEY_W-1:0] LO  = MONEY_W'(DENOM_LO);

  state_t              state_q, state_d;
  logic                flat_q, flat_d;
  logic [AMOUNT_W-1:0] amount_q, amount_d;
  logic [PRICE_W-1:0]  unit_q, unit_d;
  logic [PRICE_W-1:0]  ticket_q, ticket_d;
  logic [MONEY_W-1:0]  pay_q, pay_d;
  logic [MONEY_W-1:0]  change_q, change_d;
  logic [MONEY_W-1:0]  rem_q, rem_d;
  logic                underpay_q, underpay_d;

  logic [MONEY_W-1:0]  total;
  logic [MONEY_W-1:0]  denom;
  logic [1:0]          sel;
  logic                coin_vld;

  always_comb begin
    // Widen before multiplying so the product is never truncated to PRICE_W bits.
    total = flat_q ? MONEY_W'(ticket_q) : MONEY_W'(unit_q) * MONEY_W'(amount_q);

    if (rem_q >= HI) begin
      sel   = 2'd0;
      denom = HI;
    end else if (rem_q >= MID) begin
      sel   = 2'd1;
      denom = MID;
    end else begin
      sel   = 2'd2;
      denom = LO;
    end

    coin_vld = (state_q == DISPENSE) && (rem_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    flat_d     = flat_q;
    amount_d   = amount_q;
    unit_d     = unit_q;
    ticket_d   = ticket_q;
    pay_d      = pay_q;
    change_d   = change_q;
    rem_d      = rem_q;
    underpay_d = underpay_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          flat_d   = bus.flat_mode;
          amount_d = bus.amount;
          unit_d   = bus.unit_price;
          ticket_d = bus.ticket_price;
          pay_d    = bus.real_pay;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (pay_q >= total) begin
          change_d   = pay_q - total;
          underpay_d = 1'b0;
        end else begin
          change_d   = pay_q;
          underpay_d = 1'b1;
        end
        rem_d   = change_d;
        state_d = DISPENSE;
      end
      DISPENSE: begin
        if (coin_vld && bus.coin_ready) begin
          rem_d = rem_q - denom;
        end
        // Leaving on the accepting edge keeps done one cycle after the last coin.
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flat_q     <= 1'b0;
      amount_q   <= '0;
      unit_q     <= '0;
      ticket_q   <= '0;
      pay_q      <= '0;
      change_q   <= '0;
      rem_q      <= '0;
      underpay_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flat_q     <= flat_d;
      amount_q   <= amount_d;
      unit_q     <= unit_d;
      ticket_q   <= ticket_d;
      pay_q      <= pay_d;
      change_q   <= change_d;
      rem_q      <= rem_d;
      underpay_q <= underpay_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.coin_valid = coin_vld;
  assign bus.coin_sel   = coin_vld ? sel : 2'd0;
  assign bus.change     = change_q;
  assign bus.remaining  = rem_q;
  assign bus.underpay   = underpay_q;
  assign bus.done       = (state_q == DONE);
  assign bus.dispdata   = 32'(rem_q);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a queue-based coin / completion scoreboard.
module tb_change_dispenser;
  localparam int MONEY_W  = 8;
  localparam int PRICE_W  = 4;
  localparam int AMOUNT_W = 2;

  typedef struct {
    logic [1:0] sel;
    int         rem;
    int         cyc;
    bit         chk_cyc;
  } coin_t;

  typedef struct {
    int chg;
    bit up;
    int cyc;
    bit chk_cyc;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  coin_t coin_q[$];
  done_t done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  change_dispenser_if #(.MONEY_W(MONEY_W), .PRICE_W(PRICE_W), .AMOUNT_W(AMOUNT_W)) bus ();

  change_dispenser #(
    .MONEY_W(MONEY_W), .PRICE_W(PRICE_W), .AMOUNT_W(AMOUNT_W),
    .DENOM_HI(10), .DENOM_MID(5), .DENOM_LO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_coin(input logic [1:0] sel, input int rem, input int c, input bit chk);
    coin_t e;
    e.sel = sel; e.rem = rem; e.cyc = c; e.chk_cyc = chk;
    coin_q.push_back(e);
  endtask

  task automatic push_done(input int chg, input bit up, input int c, input bit chk);
    done_t e;
    e.chg = chg; e.up = up; e.cyc = c; e.chk_cyc = chk;
    done_q.push_back(e);
  endtask

  // Monitor: every accepted coin and every done pulse must match the head of its queue.
  always @(negedge clk) begin : monitor
    coin_t ec;
    done_t ed;
    if (!rst) begin
      if (bus.coin_valid && bus.coin_ready) begin
        check("coin_expected", coin_q.size() > 0, 1);
        if (coin_q.size() > 0) begin
          ec = coin_q.pop_front();
          check("coin_sel", bus.coin_sel, ec.sel);
          check("coin_remaining", bus.remaining, ec.rem);
          if (ec.chk_cyc) check("coin_cycle", cyc, ec.cyc);
        end
      end
      if (bus.done) begin
        check("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          ed = done_q.pop_front();
          check("done_change", bus.change, ed.chg);
          check("done_underpay", bus.underpay, ed.up);
          check("done_remaining", bus.remaining, 0);
          if (ed.chk_cyc) check("done_cycle", cyc, ed.cyc);
        end
      end
    end
  end

  task automatic start_txn(input bit flat, input int amt, input int up, input int tp,
                           input int pay, output int t);
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.flat_mode    = flat;
    bus.amount       = AMOUNT_W'(amt);
    bus.unit_price   = PRICE_W'(up);
    bus.ticket_price = PRICE_W'(tp);
    bus.real_pay     = MONEY_W'(pay);
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 300);
    check({name, "_idle"}, bus.busy, 0);
    check({name, "_coins_left"}, coin_q.size(), 0);
    check({name, "_dones_left"}, done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_coin_valid"}, bus.coin_valid, 0);
    check({name, "_coin_sel"}, bus.coin_sel, 0);
    check({name, "_change"}, bus.change, 0);
    check({name, "_remaining"}, bus.remaining, 0);
    check({name, "_underpay"}, bus.underpay, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_dispdata"}, bus.dispdata, 0);
  endtask

  initial begin : stim
    int t;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.flat_mode    = 1'b0;
    bus.amount       = '0;
    bus.unit_price   = '0;
    bus.ticket_price = '0;
    bus.real_pay     = '0;
    bus.coin_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // 3*2=6 owed from 20: change 14 -> HI, LO x4
    bus.coin_ready = 1'b1;
    start_txn(0, 2, 3, 0, 20, t);
    push_coin(2'd0, 14, t + 2, 1);
    push_coin(2'd2, 4, t + 3, 1);
    push_coin(2'd2, 3, t + 4, 1);
    push_coin(2'd2, 2, t + 5, 1);
    push_coin(2'd2, 1, t + 6, 1);
    push_done(14, 0, t + 7, 1);
    @(negedge clk);
    check("t1_calc_no_coin", bus.coin_valid, 0);
    @(negedge clk);
    check("t1_dispdata", bus.dispdata, 14);
    check("t1_change", bus.change, 14);
    wait_idle("t1");

    // flat 7 from 12: single MID
    start_txn(1, 0, 0, 7, 12, t);
    push_coin(2'd1, 5, t + 2, 1);
    push_done(5, 0, t + 3, 1);
    wait_idle("t2");

    // 4*3=12 > 10: full refund, underpay
    start_txn(0, 3, 4, 0, 10, t);
    push_coin(2'd0, 10, t + 2, 1);
    push_done(10, 1, t + 3, 1);
    wait_idle("t3");
    @(negedge clk);
    check("t3_underpay_hold", bus.underpay, 1);
    check("t3_change_hold", bus.change, 10);

    // backpressure: flat 4 from 10 -> change 6, hopper stalls 3 cycles
    bus.coin_ready = 1'b0;
    start_txn(1, 0, 0, 4, 10, t);
    push_coin(2'd1, 6, 0, 0);
    push_coin(2'd2, 1, 0, 0);
    push_done(6, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", bus.coin_valid, 1);
      check("bp_sel", bus.coin_sel, 1);
      check("bp_remaining", bus.remaining, 6);
    end
    @(posedge clk); #1;
    bus.coin_ready = 1'b1;
    wait_idle("bp");

    // zero change, plus a second start during busy that must be lost
    start_txn(0, 1, 5, 0, 5, t);
    push_done(0, 0, t + 3, 1);
    bus.start    = 1'b1;
    bus.real_pay = MONEY_W'(50);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("zero");
    repeat (5) @(negedge clk);
    check("zero_still_idle", bus.busy, 0);

    // 15*3=45 must not wrap: change 155 -> 15 HI, 1 MID
    start_txn(0, 3, 15, 0, 200, t);
    for (int i = 0; i < 15; i++) push_coin(2'd0, 155 - 10 * i, t + 2 + i, 1);
    push_coin(2'd1, 5, t + 17, 1);
    push_done(155, 0, t + 18, 1);
    wait_idle("wide");

    // reset mid-dispense with remaining=9
    bus.coin_ready = 1'b0;
    start_txn(1, 0, 0, 0, 9, t);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_remaining", bus.remaining, 9);
    check("rst_pre_valid", bus.coin_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    bus.coin_ready = 1'b1;
    start_txn(1, 0, 0, 3, 5, t);
    push_coin(2'd2, 2, t + 2, 1);
    push_coin(2'd2, 1, t + 3, 1);
    push_done(2, 0, t + 4, 1);
    wait_idle("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
